ltl_monitor_ctrl: RTL

Sequencer that feeds an 8-bit symbol trace into one generated LTL automaton cluster (e.g. `Automata_ltl3c2`) and collects its report outputs. It sits between the trace source and the automaton:
- buffers incoming symbols;
- issues the automaton reset/start-of-data sequence at each trace start;
- gates `run` against report back-pressure;
- tags each non-zero report vector with the index of the symbol that produced it.

---
 rtl/ltl_mon_pkg.sv | 21 ++
 rtl/ltl_mon_fifo.sv | 46 ++++
 rtl/ltl_monitor_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor sequencer: FSM state encoding and report FIFO entry layout.
package ltl_mon_pkg;

    localparam int LTL_MON_RPT_DEPTH   = 2;
    localparam int LTL_MON_NUM_REPORTS = 4;
    localparam int LTL_MON_IDX_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ltl_mon_state_e;

    // Field widths match the controller's default NUM_REPORTS / IDX_W.
    typedef struct packed {
        logic [LTL_MON_NUM_REPORTS-1:0] bits;
        logic [LTL_MON_IDX_W-1:0]       idx;
    } ltl_mon_rpt_t;

endpackage

// File: rtl/ltl_mon_fifo.sv
// Synchronous power-of-two FIFO with async active-high reset; head is always visible on rdata_o.
module ltl_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [AW:0]                 count_q;
    logic                        do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ltl_monitor_ctrl.sv
// Feeds a symbol trace into one LTL automaton cluster and queues its non-zero reports.
// Optional LTL_MON_REPORT_IDX_EN adds the per-symbol index counter and tags reports with it.
module ltl_monitor_ctrl
    import ltl_mon_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_REPORTS = LTL_MON_NUM_REPORTS,
    parameter int IDX_W       = LTL_MON_IDX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sym_valid,
    output logic                   sym_ready,
    input  logic [7:0]             sym_data,
    input  logic                   sym_last,
    output logic                   aut_reset,
    output logic                   aut_run,
    output logic [7:0]             aut_symbols,
    input  logic [NUM_REPORTS-1:0] aut_report,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [NUM_REPORTS-1:0] rpt_bits,
    output logic [IDX_W-1:0]       rpt_idx,
    output logic                   busy,
    output logic                   done
);
    localparam int RPT_CW = $clog2(LTL_MON_RPT_DEPTH) + 1;

    ltl_mon_state_e          state_q;
    logic                    done_q, issued_q;
    logic [7:0]              sym_hold_q;
    logic [8:0]              sym_head;
    logic                    sym_empty, sym_full, sym_push;
    logic [$clog2(DEPTH):0]  sym_count;
    logic                    rpt_empty, rpt_full, rpt_push, rpt_pop;
    logic [RPT_CW-1:0]       rpt_count;
    logic                    credit, issue;

    ltl_mon_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_sym_fifo (
        .clk_i(clk), .rst_i(reset),
        .push_i(sym_push), .wdata_i({sym_last, sym_data}),
        .pop_i(issue), .rdata_o(sym_head),
        .empty_o(sym_empty), .full_o(sym_full), .count_o(sym_count)
    );

    // With a symbol in flight its report may still land, so the FIFO must drain
    // to zero after this cycle's pop; otherwise one free slot is enough.
    assign credit    = issued_q ? (rpt_count == RPT_CW'(rpt_pop)) : !(rpt_full && !rpt_pop);
    assign issue     = (state_q == RUN) && !sym_empty && credit;
    assign sym_ready = !sym_full && !reset;
    assign sym_push  = sym_valid && sym_ready;
    assign rpt_push  = issued_q && (aut_report != '0);
    assign rpt_valid = !rpt_empty;
    assign rpt_pop   = rpt_valid && rpt_ready;

    assign aut_reset   = reset || (state_q == RESET);
    assign aut_run     = issue;
    assign aut_symbols = issue ? sym_head[7:0] : sym_hold_q;
    assign busy        = (state_q != IDLE) || (sym_count != '0);
    assign done        = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            issued_q   <= 1'b0;
            sym_hold_q <= '0;
        end else begin
            done_q   <= 1'b0;
            issued_q <= issue;
            if (issue) sym_hold_q <= sym_head[7:0];
            case (state_q)
                IDLE:    if (!sym_empty) state_q <= RESET;
                RESET:   if (!sym_empty && credit) state_q <= RUN;
                RUN:     if (issue && sym_head[8]) begin
                             state_q <= DRAIN;
                             done_q  <= 1'b1;
                         end
                DRAIN:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LTL_MON_REPORT_IDX_EN
    logic [IDX_W-1:0] idx_q, idx_d, issue_idx_q;
    ltl_mon_rpt_t     rpt_wr, rpt_rd;

    always_comb begin
        idx_d = idx_q;
        if (state_q == RESET) idx_d = '0;
        else if (issue && (idx_q != '1)) idx_d = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            issue_idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (issue) issue_idx_q <= idx_q;
        end
    end

    assign rpt_wr.bits = aut_report;
    assign rpt_wr.idx  = issue_idx_q;

    ltl_mon_fifo #(.WIDTH($bits(ltl_mon_rpt_t)), .DEPTH(LTL_MON_RPT_DEPTH)) u_rpt_fifo (
        .clk_i(clk), .rst_i(reset),
        .push_i(rpt_push), .wdata_i(rpt_wr),
        .pop_i(rpt_pop), .rdata_o(rpt_rd),
        .empty_o(rpt_empty), .full_o(rpt_full), .count_o(rpt_count)
    );

    assign rpt_bits = rpt_rd.bits;
    assign rpt_idx  = rpt_rd.idx;
`else
    logic [NUM_REPORTS-1:0] rpt_rd;

    ltl_mon_fifo #(.WIDTH(NUM_REPORTS), .DEPTH(LTL_MON_RPT_DEPTH)) u_rpt_fifo (
        .clk_i(clk), .rst_i(reset),
        .push_i(rpt_push), .wdata_i(aut_report),
        .pop_i(rpt_pop), .rdata_o(rpt_rd),
        .empty_o(rpt_empty), .full_o(rpt_full), .count_o(rpt_count)
    );

    assign rpt_bits = rpt_rd;
    assign rpt_idx  = '0;
`endif

endmodule
